// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the 5-stage pipelined datapath. It
// keeps its own small copy of what sits in the E, M and W stages. From that
// copy and the incoming D-stage instruction it works out:
//   - which source each E-stage operand should be forwarded from,
//   - when a load/link result is needed too early (use stall),
//   - when a taken branch must squash the younger instructions,
//   - when a load in M is waiting on data memory (memory stall).
// It also keeps two saturating performance counters.
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   rs_d          D-stage source addresses, operand i at [i*REG_W +: REG_W]
//   use_rs_d      bit i set when the D instruction really reads operand i
//   rd_d          D-stage destination register
//   regwrite_d    D instruction writes rd_d
//   resultsrc_d   result source of D: 00 ALU, 01 load, 10 PC+4 (link)
//   branch_e      taken branch/jump resolved in E
//   dmem_ready    data memory finishes the load held in M this cycle
//   StallF..M     hold PC, F/D, D/E and E/M pipeline registers
//   FlushD/E/W    turn F/D, D/E and M/W into bubbles
//   ForwardE      per operand: 00 regfile, 01 ResultW, 10 ALUResult_M
//   stall_cnt     cycles spent with StallD high (saturating)
//   flush_cnt     taken branches acted on (saturating)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int COUNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*REG_W-1:0] rs_d,
  input  logic [NUM_SRC-1:0]       use_rs_d,
  input  logic [REG_W-1:0]         rd_d,
  input  logic                     regwrite_d,
  input  logic [1:0]               resultsrc_d,
  input  logic                     branch_e,
  input  logic                     dmem_ready,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushW,
  output logic [NUM_SRC*2-1:0]     ForwardE,
  output logic [COUNT_W-1:0]       stall_cnt,
  output logic [COUNT_W-1:0]       flush_cnt
);

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;

  // E-stage record
  logic                     e_valid_q, e_valid_d;
  logic [NUM_SRC*REG_W-1:0] e_rs_q, e_rs_d;
  logic [NUM_SRC-1:0]       e_use_q, e_use_d;
  logic [REG_W-1:0]         e_rd_q, e_rd_d;
  logic                     e_regwrite_q, e_regwrite_d;
  logic [1:0]               e_resultsrc_q, e_resultsrc_d;

  // M-stage record
  logic                     m_valid_q, m_valid_d;
  logic [REG_W-1:0]         m_rd_q, m_rd_d;
  logic                     m_regwrite_q, m_regwrite_d;
  logic [1:0]               m_resultsrc_q, m_resultsrc_d;

  // W-stage record
  logic                     w_valid_q, w_valid_d;
  logic [REG_W-1:0]         w_rd_q, w_rd_d;
  logic                     w_regwrite_q, w_regwrite_d;

  // Performance counters
  logic [COUNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [COUNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic e_writer, m_writer, w_writer;
  logic use_hit, use_stall, mem_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [NUM_SRC*2-1:0] forward_e;

  // A stage only counts as producing a register if it holds a real
  // instruction that writes something other than x0; x0 is hardwired to
  // zero so it must never cause a stall or a forward.
  always_comb begin
    e_writer  = e_valid_q & e_regwrite_q & (e_rd_q != '0);
    m_writer  = m_valid_q & m_regwrite_q & (m_rd_q != '0);
    w_writer  = w_valid_q & w_regwrite_q & (w_rd_q != '0);
    mem_stall = m_valid_q & (m_resultsrc_q == RES_LOAD) & ~dmem_ready;
  end

  // A load or link result in E is not available until W, so a D instruction
  // reading it must wait one cycle; after that the value comes through the
  // W forwarding path.
  always_comb begin
    use_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (use_rs_d[i] && (rs_d[i*REG_W +: REG_W] == e_rd_q)) begin
        use_hit = 1'b1;
      end
    end
    use_stall = e_writer & (e_resultsrc_q != RES_ALU) & use_hit;
  end

  // Stall/flush arbitration. A memory stall freezes the whole front of the
  // pipe, so a branch resolved in E simply waits (E holds) and is acted on
  // once memory answers. A taken branch squashes the instruction in D anyway,
  // so a pending use stall against it is irrelevant and is dropped.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (branch_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (use_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Forwarding select for each E operand. The newer value in M wins over the
  // older one in W. Only ALU results exist in M; a load/link in M can never
  // match here because the use stall already spaced the consumer out.
  always_comb begin
    forward_e = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (e_use_q[i] && m_writer && (m_resultsrc_q == RES_ALU) &&
            (m_rd_q == e_rs_q[i*REG_W +: REG_W])) begin
          forward_e[i*2 +: 2] = FWD_M;
        end else if (e_use_q[i] && w_writer &&
                     (w_rd_q == e_rs_q[i*REG_W +: REG_W])) begin
          forward_e[i*2 +: 2] = FWD_W;
        end else begin
          forward_e[i*2 +: 2] = FWD_REGFILE;
        end
      end
    end
  end

  // Advance the shadow pipeline. While memory stalls, E and M stay put and
  // the W slot becomes a bubble, matching the flushed M/W register in the
  // datapath. Otherwise everything shifts one stage and E picks up the D
  // instruction, marked invalid when the D/E register is being flushed.
  always_comb begin
    e_valid_d     = e_valid_q;
    e_rs_d        = e_rs_q;
    e_use_d       = e_use_q;
    e_rd_d        = e_rd_q;
    e_regwrite_d  = e_regwrite_q;
    e_resultsrc_d = e_resultsrc_q;
    m_valid_d     = m_valid_q;
    m_rd_d        = m_rd_q;
    m_regwrite_d  = m_regwrite_q;
    m_resultsrc_d = m_resultsrc_q;
    w_valid_d     = w_valid_q;
    w_rd_d        = w_rd_q;
    w_regwrite_d  = w_regwrite_q;
    if (mem_stall) begin
      w_valid_d = 1'b0;
    end else begin
      w_valid_d     = m_valid_q;
      w_rd_d        = m_rd_q;
      w_regwrite_d  = m_regwrite_q;
      m_valid_d     = e_valid_q;
      m_rd_d        = e_rd_q;
      m_regwrite_d  = e_regwrite_q;
      m_resultsrc_d = e_resultsrc_q;
      e_valid_d     = ~flush_e;
      e_rs_d        = rs_d;
      e_use_d       = use_rs_d;
      e_rd_d        = rd_d;
      e_regwrite_d  = regwrite_d;
      e_resultsrc_d = resultsrc_d;
    end
  end

  // Counters stick at all-ones instead of wrapping so a long run still reads
  // as "very many" rather than a small misleading number.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + COUNT_W'(1);
    end
    if (branch_e && !mem_stall && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + COUNT_W'(1);
    end
  end

  // State registers; reset empties every stage so any hazard in flight at
  // the time of reset is forgotten.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q     <= 1'b0;
      e_rs_q        <= '0;
      e_use_q       <= '0;
      e_rd_q        <= '0;
      e_regwrite_q  <= 1'b0;
      e_resultsrc_q <= RES_ALU;
      m_valid_q     <= 1'b0;
      m_rd_q        <= '0;
      m_regwrite_q  <= 1'b0;
      m_resultsrc_q <= RES_ALU;
      w_valid_q     <= 1'b0;
      w_rd_q        <= '0;
      w_regwrite_q  <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      e_valid_q     <= e_valid_d;
      e_rs_q        <= e_rs_d;
      e_use_q       <= e_use_d;
      e_rd_q        <= e_rd_d;
      e_regwrite_q  <= e_regwrite_d;
      e_resultsrc_q <= e_resultsrc_d;
      m_valid_q     <= m_valid_d;
      m_rd_q        <= m_rd_d;
      m_regwrite_q  <= m_regwrite_d;
      m_resultsrc_q <= m_resultsrc_d;
      w_valid_q     <= w_valid_d;
      w_rd_q        <= w_rd_d;
      w_regwrite_q  <= w_regwrite_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Drive the ports; counters read as zero while reset is held.
  always_comb begin
    StallF    = stall_f;
    StallD    = stall_d;
    StallE    = stall_e;
    StallM    = stall_m;
    FlushD    = flush_d;
    FlushE    = flush_e;
    FlushW    = flush_w;
    ForwardE  = forward_e;
    stall_cnt = reset ? '0 : stall_cnt_q;
    flush_cnt = reset ? '0 : flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Drives short instruction sequences into a 3-operand hazard_scoreboard with
// 3-bit counters (so saturation is reachable quickly). Each driven cycle
// pushes the outputs expected for that cycle onto a queue; a monitor pops
// them on the falling edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int NUM_SRC = 3;
   localparam int REG_W   = 5;
   localparam int COUNT_W = 3;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_USE  = 7'b1100010;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_MEM  = 7'b1111001;
   localparam logic [6:0] C_RST  = 7'b0000110;

   typedef struct {
      string      tag;
      logic [6:0] ctl;
      logic [5:0] fwd;
      int         sc;
      int         fc;
   } expect_t;

   logic                     clock;
   logic                     reset;
   logic [NUM_SRC*REG_W-1:0] rsD;
   logic [NUM_SRC-1:0]       useRsD;
   logic [REG_W-1:0]         rdD;
   logic                     regwriteD;
   logic [1:0]               resultsrcD;
   logic                     branchE;
   logic                     dmemReady;
   logic                     stallF, stallD, stallE, stallM;
   logic                     flushD, flushE, flushW;
   logic [NUM_SRC*2-1:0]     forwardE;
   logic [COUNT_W-1:0]       stallCnt, flushCnt;

   expect_t expQ[$];
   int testsRun = 0;
   int testsFailed = 0;

   hazard_scoreboard #(
      .NUM_SRC(NUM_SRC),
      .REG_W  (REG_W),
      .COUNT_W(COUNT_W)
   ) dut (
      .clk        (clock),
      .reset      (reset),
      .rs_d       (rsD),
      .use_rs_d   (useRsD),
      .rd_d       (rdD),
      .regwrite_d (regwriteD),
      .resultsrc_d(resultsrcD),
      .branch_e   (branchE),
      .dmem_ready (dmemReady),
      .StallF     (stallF),
      .StallD     (stallD),
      .StallE     (stallE),
      .StallM     (stallM),
      .FlushD     (flushD),
      .FlushE     (flushE),
      .FlushW     (flushW),
      .ForwardE   (forwardE),
      .stall_cnt  (stallCnt),
      .flush_cnt  (flushCnt)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog so the run always ends even if something wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required normal end");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when observed and expected differ
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
      end
   endtask

   // Drives one D-stage instruction for one cycle and queues the outputs the
   // DUT should show during that cycle
   task automatic applyStimulus(input string tag, input logic rst,
                                input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] useBits,
                                input logic [4:0] rd, input logic rw,
                                input logic [1:0] rsrc, input logic br,
                                input logic rdy, input logic [6:0] eCtl,
                                input logic [5:0] eFwd, input int eSc, input int eFc);
      expect_t e;
      @(posedge clock);
      #1;
      reset      = rst;
      rsD        = {rs2, rs1, rs0};
      useRsD     = useBits;
      rdD        = rd;
      regwriteD  = rw;
      resultsrcD = rsrc;
      branchE    = br;
      dmemReady  = rdy;
      e.tag = tag;
      e.ctl = eCtl;
      e.fwd = eFwd;
      e.sc  = eSc;
      e.fc  = eFc;
      expQ.push_back(e);
   endtask

   task automatic nopCycle(input string tag, input logic br, input logic rdy,
                           input logic [6:0] eCtl, input logic [5:0] eFwd,
                           input int eSc, input int eFc);
      applyStimulus(tag, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 2'b00,
                    br, rdy, eCtl, eFwd, eSc, eFc);
   endtask

   task automatic resetCycle(input string tag);
      applyStimulus(tag, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 2'b00,
                    1'b0, 1'b1, C_RST, 6'b0, 0, 0);
   endtask

   // Scoreboard side: compare whatever the DUT shows against the oldest entry
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         expect_t e;
         e = expQ.pop_front();
         checkOutput({e.tag, "_ctl"},
                     64'({stallF, stallD, stallE, stallM, flushD, flushE, flushW}),
                     64'(e.ctl));
         checkOutput({e.tag, "_fwd"}, 64'(forwardE), 64'(e.fwd));
         checkOutput({e.tag, "_scnt"}, 64'(stallCnt), 64'(e.sc));
         checkOutput({e.tag, "_fcnt"}, 64'(flushCnt), 64'(e.fc));
      end
   end

   initial begin
      reset = 1'b1; rsD = '0; useRsD = '0; rdD = '0; regwriteD = 1'b0;
      resultsrcD = 2'b00; branchE = 1'b0; dmemReady = 1'b1;

      // Reset value and first idle cycle
      resetCycle("reset");
      nopCycle("idle", 1'b0, 1'b1, C_NONE, 6'b0, 0, 0);

      // add x5 ; add x6,x5,x1 -> forward from M
      resetCycle("fm_rst");
      applyStimulus("fm_add5", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("fm_add6", 0, 5'd5, 5'd1, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("fm_e", 0, 1, C_NONE, 6'b000010, 0, 0);

      // add x5 ; nop ; sub x7,x5,x5 -> both operands from W
      resetCycle("fw_rst");
      applyStimulus("fw_add5", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("fw_nop", 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("fw_sub", 0, 5'd5, 5'd5, 5'd0, 3'b011, 5'd7, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("fw_e", 0, 1, C_NONE, 6'b000101, 0, 0);

      // add x5 ; add x5 ; add x6,x5,x5 -> M wins over W
      resetCycle("pr_rst");
      applyStimulus("pr_a", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("pr_b", 0, 5'd3, 5'd4, 5'd0, 3'b011, 5'd5, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("pr_c", 0, 5'd5, 5'd5, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("pr_e", 0, 1, C_NONE, 6'b001010, 0, 0);

      // lw x5 ; add x6,x5,x0 -> one use stall, then W forward
      resetCycle("lu_rst");
      applyStimulus("lu_lw", 0, 5'd1, 5'd0, 5'd0, 3'b001, 5'd5, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("lu_stall", 0, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_USE, 6'b0, 0, 0);
      applyStimulus("lu_retry", 0, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_NONE, 6'b0, 1, 0);
      nopCycle("lu_e", 0, 1, C_NONE, 6'b000001, 1, 0);

      // add x5 ; lw x9 ; sub x7,x5,x5 with memory not ready for 3 cycles
      resetCycle("ms_rst");
      applyStimulus("ms_add5", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("ms_lw9", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("ms_sub", 0, 5'd5, 5'd5, 5'd0, 3'b011, 5'd7, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("ms_st1", 0, 0, C_MEM, 6'b000101, 0, 0);
      nopCycle("ms_st2", 0, 0, C_MEM, 6'b0, 1, 0);
      nopCycle("ms_st3", 0, 0, C_MEM, 6'b0, 2, 0);
      nopCycle("ms_rel", 0, 1, C_NONE, 6'b0, 3, 0);
      nopCycle("ms_after", 0, 1, C_NONE, 6'b0, 3, 0);

      // Branch beats a use stall; branch waits out a memory stall
      resetCycle("br_rst");
      applyStimulus("br_lw", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("br_use", 0, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 1, 1, C_BR, 6'b0, 0, 0);
      nopCycle("br_mem", 1, 0, C_MEM, 6'b0, 0, 1);
      nopCycle("br_late", 1, 1, C_BR, 6'b0, 1, 1);
      nopCycle("br_done", 0, 1, C_NONE, 6'b0, 1, 2);

      // x0 never produces, operand 2 forwards
      resetCycle("x0_rst");
      applyStimulus("x0_wr", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd0, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("x0_rd", 0, 5'd0, 5'd0, 5'd0, 3'b111, 5'd3, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("x0_em", 0, 1, C_NONE, 6'b000000, 0, 0);
      nopCycle("x0_w", 0, 1, C_NONE, 6'b000000, 0, 0);
      applyStimulus("x0_lw", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("x0_lrd", 0, 5'd0, 5'd0, 5'd0, 3'b111, 5'd3, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("x0_nost", 0, 1, C_NONE, 6'b000000, 0, 0);
      applyStimulus("op2_add8", 0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd8, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("op2_fma", 0, 5'd1, 5'd2, 5'd8, 3'b111, 5'd9, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("op2_e", 0, 1, C_NONE, 6'b100000, 0, 0);

      // Reset during a memory stall and during a use stall
      resetCycle("rm_rst");
      applyStimulus("rm_lw", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("rm_nop", 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("rm_mem", 0, 0, C_MEM, 6'b0, 0, 0);
      applyStimulus("rm_hit", 1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 0, 2'b00, 0, 0, C_RST, 6'b0, 0, 0);
      nopCycle("rm_clr", 0, 0, C_NONE, 6'b0, 0, 0);
      applyStimulus("ru_lw", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      applyStimulus("ru_use", 0, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_USE, 6'b0, 0, 0);
      applyStimulus("ru_hit", 1, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_RST, 6'b0, 0, 0);
      applyStimulus("ru_clr", 0, 5'd5, 5'd0, 5'd0, 3'b011, 5'd6, 1, 2'b00, 0, 1, C_NONE, 6'b0, 0, 0);

      // Stall counter saturates at 7
      resetCycle("ss_rst");
      applyStimulus("ss_lw", 0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1, 2'b01, 0, 1, C_NONE, 6'b0, 0, 0);
      nopCycle("ss_nop", 0, 1, C_NONE, 6'b0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         nopCycle("ss_mem", 0, 0, C_MEM, 6'b0, (k > 7) ? 7 : k, 0);
      end
      nopCycle("ss_end", 0, 1, C_NONE, 6'b0, 7, 0);

      // Flush counter saturates at 7
      resetCycle("fs_rst");
      for (int k = 0; k < 9; k++) begin
         nopCycle("fs_br", 1, 1, C_BR, 6'b0, 0, (k > 7) ? 7 : k);
      end
      nopCycle("fs_end", 0, 1, C_NONE, 6'b0, 0, 7);

      @(negedge clock);
      #1;
      checkOutput("drain", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
